// File: rtl/lp_unroll_seq_if.sv
// Bundle between the loop unroll sequencer and its neighbours: loop-start request from the
// loop address table, group stream to the interpreter, and fetch-stall / status signals.
interface lp_unroll_seq_if #(
  parameter int PC_W  = 16,
  parameter int CNT_W = 7
);
  logic             lp_strt_in;
  logic [PC_W-1:0]  lp_pc_in;
  logic [CNT_W-1:0] lp_len_in;
  logic [CNT_W-1:0] lp_unroll_in;
  logic             grp_rdy_in;
  logic             mis_pred_in;

  logic             grp_vld_out;
  logic [PC_W-1:0]  grp_pc_out;
  logic [3:0]       inst_valid_out;
  logic [CNT_W-1:0] iter_out;
  logic             last_grp_out;
  logic             stll_ftch_out;
  logic             fnsh_unrll_out;
  logic             busy_out;
  logic [1:0]       lbd_state_out;

  modport master (
    output lp_strt_in, lp_pc_in, lp_len_in, lp_unroll_in, grp_rdy_in, mis_pred_in,
    input  grp_vld_out, grp_pc_out, inst_valid_out, iter_out, last_grp_out,
           stll_ftch_out, fnsh_unrll_out, busy_out, lbd_state_out
  );

  modport slave (
    input  lp_strt_in, lp_pc_in, lp_len_in, lp_unroll_in, grp_rdy_in, mis_pred_in,
    output grp_vld_out, grp_pc_out, inst_valid_out, iter_out, last_grp_out,
           stll_ftch_out, fnsh_unrll_out, busy_out, lbd_state_out
  );
endinterface

// File: rtl/lp_unroll_seq.sv
// Loop unroll sequencer: replays a latched loop body as 4-wide instruction groups for the
// requested number of iterations, stalling fetch meanwhile and aborting on mispredict.
module lp_unroll_seq #(
  parameter int PC_W    = 16,
  parameter int CNT_W   = 7,
  parameter int MAX_LEN = 64
) (
  input logic            clk,
  input logic            rst,
  lp_unroll_seq_if.slave bus
);

  localparam int OW = CNT_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    REPLAY = 2'b01,
    DONE   = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] unroll_q, unroll_d;
  logic [OW-1:0]    offset_q, offset_d;
  logic [CNT_W-1:0] iter_q, iter_d;

  logic [OW-1:0]    rem;
  logic             in_replay;
  logic             last_grp;
  logic             xfer;
  logic             accept;

  // Offset is carried one bit wider than the length so a 64-instruction body never aliases.
  assign rem       = {1'b0, len_q} - offset_q;
  assign in_replay = (state_q == REPLAY);
  assign last_grp  = (rem <= OW'(4)) && (iter_q == (unroll_q - CNT_W'(1)));
  assign xfer      = in_replay && bus.grp_rdy_in;
  assign accept    = bus.lp_strt_in && !bus.mis_pred_in &&
                     (bus.lp_len_in != '0) &&
                     ({1'b0, bus.lp_len_in} <= OW'(MAX_LEN)) &&
                     (bus.lp_unroll_in != '0);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    len_d    = len_q;
    unroll_d = unroll_q;
    offset_d = offset_q;
    iter_d   = iter_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = REPLAY;
          pc_d     = bus.lp_pc_in;
          len_d    = bus.lp_len_in;
          unroll_d = bus.lp_unroll_in;
          offset_d = '0;
          iter_d   = '0;
        end
      end
      REPLAY: begin
        // Mispredict wins over both group advance and completion.
        if (bus.mis_pred_in) begin
          state_d  = IDLE;
          offset_d = '0;
          iter_d   = '0;
        end else if (xfer) begin
          if (rem > OW'(4)) begin
            offset_d = offset_q + OW'(4);
          end else begin
            offset_d = '0;
            iter_d   = iter_q + CNT_W'(1);
            if (last_grp) begin
              state_d = DONE;
            end
          end
        end
      end
      DONE: begin
        state_d  = IDLE;
        offset_d = '0;
        iter_d   = '0;
      end
      default: begin
        state_d  = IDLE;
        offset_d = '0;
        iter_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      len_q    <= '0;
      unroll_q <= '0;
      offset_q <= '0;
      iter_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      len_q    <= len_d;
      unroll_q <= unroll_d;
      offset_q <= offset_d;
      iter_q   <= iter_d;
    end
  end

  // Group fields are forced to zero outside REPLAY so idle outputs stay clean.
  always_comb begin
    bus.inst_valid_out = 4'b0000;
    if (in_replay) begin
      if (rem >= OW'(4)) begin
        bus.inst_valid_out = 4'b1111;
      end else begin
        case (rem[1:0])
          2'd3:    bus.inst_valid_out = 4'b1110;
          2'd2:    bus.inst_valid_out = 4'b1100;
          2'd1:    bus.inst_valid_out = 4'b1000;
          default: bus.inst_valid_out = 4'b0000;
        endcase
      end
    end
  end

  assign bus.grp_vld_out    = in_replay;
  assign bus.stll_ftch_out  = in_replay;
  assign bus.busy_out       = (state_q != IDLE);
  assign bus.fnsh_unrll_out = (state_q == DONE);
  assign bus.lbd_state_out  = state_q;
  assign bus.grp_pc_out     = in_replay ? (pc_q + PC_W'(offset_q)) : '0;
  assign bus.iter_out       = in_replay ? iter_q : '0;
  assign bus.last_grp_out   = in_replay && last_grp;

endmodule

// File: tb/tb_lp_unroll_seq.sv
// Directed bench for lp_unroll_seq: expected groups are queued when a loop is started and
// popped as the sequencer hands them off.
module tb_lp_unroll_seq;

  localparam int PC_W  = 16;
  localparam int CNT_W = 7;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [3:0]       mask;
    logic [CNT_W-1:0] iter;
    logic             last;
  } grp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  grp_t exp_q[$];

  lp_unroll_seq_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  lp_unroll_seq #(.PC_W(PC_W), .CNT_W(CNT_W), .MAX_LEN(64)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Independent model of the group stream for one accepted loop.
  task automatic pushLoop(input logic [PC_W-1:0] pc, input int len, input int unroll);
    grp_t e;
    for (int it = 0; it < unroll; it++) begin
      for (int off = 0; off < len; off += 4) begin
        int r;
        r      = len - off;
        e.pc   = pc + PC_W'(off);
        e.mask = (r >= 4) ? 4'b1111 : (r == 3) ? 4'b1110 : (r == 2) ? 4'b1100 : 4'b1000;
        e.iter = CNT_W'(it);
        e.last = (it == unroll - 1) && (r <= 4);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic applyStimulus(input logic [PC_W-1:0] pc, input int len, input int unroll,
                               input bit expect_accept);
    bus.lp_strt_in   = 1'b1;
    bus.lp_pc_in     = pc;
    bus.lp_len_in    = CNT_W'(len);
    bus.lp_unroll_in = CNT_W'(unroll);
    if (expect_accept) pushLoop(pc, len, unroll);
    nextCycle();
    bus.lp_strt_in = 1'b0;
    checkOutput("start_state", 32'(bus.lbd_state_out), expect_accept ? 32'd1 : 32'd0);
    checkOutput("start_busy", 32'(bus.busy_out), 32'(expect_accept));
  endtask

  task automatic checkIdleZero();
    checkOutput("idle_state", 32'(bus.lbd_state_out), 32'd0);
    checkOutput("idle_vld", 32'(bus.grp_vld_out), 32'd0);
    checkOutput("idle_stall", 32'(bus.stll_ftch_out), 32'd0);
    checkOutput("idle_fnsh", 32'(bus.fnsh_unrll_out), 32'd0);
    checkOutput("idle_busy", 32'(bus.busy_out), 32'd0);
    checkOutput("idle_pc", 32'(bus.grp_pc_out), 32'd0);
    checkOutput("idle_mask", 32'(bus.inst_valid_out), 32'd0);
    checkOutput("idle_iter", 32'(bus.iter_out), 32'd0);
    checkOutput("idle_last", 32'(bus.last_grp_out), 32'd0);
  endtask

  task automatic checkDone();
    checkOutput("done_state", 32'(bus.lbd_state_out), 32'd2);
    checkOutput("done_fnsh", 32'(bus.fnsh_unrll_out), 32'd1);
    checkOutput("done_stall", 32'(bus.stll_ftch_out), 32'd0);
    checkOutput("done_vld", 32'(bus.grp_vld_out), 32'd0);
    checkOutput("done_busy", 32'(bus.busy_out), 32'd1);
    checkOutput("sb_empty", 32'(exp_q.size()), 32'd0);
    nextCycle();
    checkIdleZero();
  endtask

  // Consumes groups while REPLAY; optionally holds rdy low on one group, or fires a
  // mispredict (kind 1) / reset (kind 2) while a given group is presented.
  task automatic runGroups(input int hold_grp, input int hold_len, input int abort_grp,
                           input int abort_kind, output int stall_cycles);
    int   g;
    int   held;
    grp_t e;
    g = 0;
    held = 0;
    stall_cycles = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (bus.lbd_state_out != 2'b01) break;
      bus.grp_rdy_in = 1'b1;
      if (g == hold_grp && held < hold_len) begin
        bus.grp_rdy_in = 1'b0;
        held++;
      end
      if (bus.stll_ftch_out) stall_cycles++;
      checkOutput("rep_vld", 32'(bus.grp_vld_out), 32'd1);
      checkOutput("rep_busy", 32'(bus.busy_out), 32'd1);
      if (exp_q.size() == 0) begin
        checkOutput("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = exp_q[0];
        checkOutput("grp_pc", 32'(bus.grp_pc_out), 32'(e.pc));
        checkOutput("grp_mask", 32'(bus.inst_valid_out), 32'(e.mask));
        checkOutput("grp_iter", 32'(bus.iter_out), 32'(e.iter));
        checkOutput("grp_last", 32'(bus.last_grp_out), 32'(e.last));
        if (bus.grp_rdy_in) void'(exp_q.pop_front());
      end
      if (g == abort_grp) begin
        if (abort_kind == 1) bus.mis_pred_in = 1'b1;
        else rst = 1'b1;
        nextCycle();
        bus.mis_pred_in = 1'b0;
        rst = 1'b0;
        bus.grp_rdy_in = 1'b0;
        exp_q.delete();
        return;
      end
      if (bus.grp_rdy_in) g++;
      nextCycle();
      if (cyc == 299) checkOutput("replay_timeout", 32'd1, 32'd0);
    end
    bus.grp_rdy_in = 1'b0;
  endtask

  initial begin
    int stalls;
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    bus.lp_strt_in   = 1'b0;
    bus.lp_pc_in     = '0;
    bus.lp_len_in    = '0;
    bus.lp_unroll_in = '0;
    bus.grp_rdy_in   = 1'b0;
    bus.mis_pred_in  = 1'b0;
    nextCycle();
    nextCycle();
    checkIdleZero();
    rst = 1'b0;
    nextCycle();

    $display("[TB] basic replay len=10 unroll=2");
    applyStimulus(16'h0100, 10, 2, 1'b1);
    runGroups(-1, 0, -1, 0, stalls);
    checkOutput("t1_stall_cycles", 32'(stalls), 32'd6);
    checkDone();

    $display("[TB] backpressure on second group");
    applyStimulus(16'h0100, 10, 2, 1'b1);
    runGroups(1, 3, -1, 0, stalls);
    checkOutput("t2_stall_cycles", 32'(stalls), 32'd9);
    checkDone();

    $display("[TB] mispredict at second group of iteration 1");
    applyStimulus(16'h0100, 10, 2, 1'b1);
    runGroups(-1, 0, 4, 1, stalls);
    checkIdleZero();
    nextCycle();
    checkIdleZero();

    $display("[TB] illegal starts and start while busy");
    applyStimulus(16'h0100, 0, 1, 1'b0);
    applyStimulus(16'h0100, 4, 0, 1'b0);
    applyStimulus(16'h0100, 65, 2, 1'b0);
    bus.mis_pred_in = 1'b1;
    applyStimulus(16'h0100, 4, 1, 1'b0);
    bus.mis_pred_in = 1'b0;
    applyStimulus(16'h0200, 8, 1, 1'b1);
    bus.lp_strt_in   = 1'b1;
    bus.lp_pc_in     = 16'h0AAA;
    bus.lp_len_in    = 7'd3;
    bus.lp_unroll_in = 7'd5;
    nextCycle();
    bus.lp_strt_in = 1'b0;
    runGroups(-1, 0, -1, 0, stalls);
    checkOutput("t4_stall_cycles", 32'(stalls), 32'd2);
    checkDone();

    $display("[TB] single-instruction body and pc wrap");
    applyStimulus(16'h0300, 1, 3, 1'b1);
    runGroups(-1, 0, -1, 0, stalls);
    checkOutput("t5a_stall_cycles", 32'(stalls), 32'd3);
    checkDone();
    applyStimulus(16'hFFFE, 4, 1, 1'b1);
    runGroups(-1, 0, -1, 0, stalls);
    checkOutput("t5b_stall_cycles", 32'(stalls), 32'd1);
    checkDone();

    $display("[TB] max-length body with reset mid-replay");
    applyStimulus(16'h1000, 64, 1, 1'b1);
    runGroups(-1, 0, 8, 2, stalls);
    checkIdleZero();

    $display("[TB] max-length body to completion");
    applyStimulus(16'h2000, 64, 1, 1'b1);
    runGroups(-1, 0, -1, 0, stalls);
    checkOutput("t6_stall_cycles", 32'(stalls), 32'd16);
    checkDone();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
